// File: rtl/delay_stage.sv
// One DW-wide pipeline register with enable and asynchronous clear.
// Latency: 1 enabled clock edge from d to q.
// Backpressure: en=0 holds q. There is no ready signal.
module delay_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/delay_chain.sv
// Fixed-latency delay line of LEN registers. LEN=0 degenerates to a wire.
// Latency: LEN enabled clock edges. Disabled edges do not count toward the latency.
// Backpressure: en=0 freezes every stage at once, with no bubbles and no partial shift.
module delay_chain #(
    parameter int DW  = 8,
    parameter int LEN = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] in,
    output logic [DW-1:0] out
);

    generate
        if (LEN == 0) begin : g_wire
            // Clock, reset and enable are intentionally unused on the wire path.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign out = in;
        end else begin : g_chain
            logic [DW-1:0] stage_q [LEN];

            for (genvar i = 0; i < LEN; i++) begin : g_stage
                logic [DW-1:0] stage_d;
                if (i == 0) begin : g_head
                    assign stage_d = in;
                end else begin : g_link
                    assign stage_d = stage_q[i-1];
                end

                delay_stage #(.DW(DW)) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (en),
                    .d     (stage_d),
                    .q     (stage_q[i])
                );
            end

            assign out = stage_q[LEN-1];
        end
    endgenerate

endmodule

// File: tb/tb_delay_chain.sv
// Directed and random checks of delay_chain for LEN=5, LEN=0 and LEN=1/DW=1.
`timescale 1ns/1ps
module tb_delay_chain;
    localparam int LEN = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] din, dout;
    logic [7:0] din0, dout0;
    logic       din1, dout1;

    always #5 clk = ~clk;

    delay_chain #(.DW(8), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .out(dout)
    );
    delay_chain #(.DW(8), .LEN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din0), .out(dout0)
    );
    delay_chain #(.DW(1), .LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din1), .out(dout1)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [$];
    logic       exp1;
    logic [7:0] held;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_out();
        if (sb.size() >= LEN) return sb[sb.size()-LEN];
        return 8'h00;
    endfunction

    // Drive one cycle of stimulus, update the reference on the edge, then compare.
    task automatic step(input logic e, input logic [7:0] d, input logic d1, input string tag);
        en   = e;
        din  = d;
        din1 = d1;
        din0 = 8'($urandom);
        #1;
        check({tag, "_len0"}, dout0, din0);
        @(posedge clk);
        if (rst_n && e) begin
            sb.push_back(d);
            if (sb.size() > LEN) void'(sb.pop_front());
            exp1 = d1;
        end
        #1;
        check(tag, dout, model_out());
        check({tag, "_len1"}, {7'b0, dout1}, {7'b0, exp1});
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 8'h00;
        din0  = 8'h00;
        din1  = 1'b0;
        exp1  = 1'b0;
        held  = 8'h00;
        sb.delete();
        #1;
        check("reset_out", dout, 8'h00);
        check("reset_out1", {7'b0, dout1}, 8'h00);

        // Reset held with random input and enable.
        repeat (4) step(1'b1, 8'($urandom), 1'($urandom), "rst_hold");
        rst_n = 1'b1;

        // Latency: zeros for 4 edges, then the stream in order.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'(8'h11 * (k + 1)), 1'($urandom), "latency");
            check("latency_abs", dout, (k >= 4) ? 8'(8'h11 * (k - 3)) : 8'h00);
        end

        // Stall mid-stream.
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hB0 + k), 1'($urandom), "pre_stall");
        held = dout;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'($urandom), 1'($urandom), "stall");
            check("stall_frozen", dout, held);
        end
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hC0 + k), 1'($urandom), "resume");

        // Mid-stream asynchronous reset.
        repeat (LEN) step(1'b1, 8'hAA, 1'b1, "fill_aa");
        check("full_aa", dout, 8'hAA);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp1 = 1'b0;
        #1;
        check("async_rst", dout, 8'h00);
        check("async_rst1", {7'b0, dout1}, 8'h00);
        rst_n = 1'b1;
        #1;
        for (int j = 1; j <= LEN + 2; j++) begin
            step(1'b1, (j == 1) ? 8'h55 : 8'(j), 1'($urandom), "post_rst");
            check("post_rst_abs", dout, (j < LEN) ? 8'h00 : ((j == LEN) ? 8'h55 : 8'(j - LEN + 1)));
        end

        // Random enable and data.
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
